// File: rtl/led_cube_pkg.sv
// Shared constants and sequencer state encoding for the LED-cube config command path.
package led_cube_pkg;

    localparam logic [3:0] CONF_MODE   = 4'h0;
    localparam logic [3:0] CONF_BRIGHT = 4'ha;

    // Selects animation 1 and leaves mode/brightness alone, so re-applying it is harmless.
    localparam logic [7:0] CFG_IDLE_BYTE = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_FRAME
    } seq_state_e;

    function automatic logic is_mode_cmd(input logic [3:0] conf_idx);
        return conf_idx == CONF_MODE;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, wrapping pointers, exact occupancy count.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;

    // NOTE: level_d gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        level_d = level_q;
        if (push_i && !pop_i) begin
            level_d = level_q + LVL_ONE;
        end else if (!push_i && pop_i) begin
            level_d = level_q - LVL_ONE;
        end
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/cfg_cmd_sequencer.sv
// Queues UART config bytes and issues them in order, holding mode changes until the frame ends.
module cfg_cmd_sequencer
    import led_cube_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        frame_busy,
    output logic [7:0]                  cfg_byte,
    output logic                        stall_mode_change,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    seq_state_e state_q, state_d;
    logic [7:0] cfg_byte_q, cfg_byte_d;
    logic       stall_q, stall_d;
    logic       overflow_q, overflow_d;

    logic [7:0] head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    // A pop frees a slot at the same edge, so a full FIFO still accepts a simultaneous push.
    assign push = rx_valid && (!fifo_full || pop);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (rx_data),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cfg_byte_d = cfg_byte_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (!is_mode_cmd(head[7:4]) || !frame_busy) begin
                        pop        = 1'b1;
                        cfg_byte_d = head;
                        state_d    = ST_ISSUE;
                    end else begin
                        state_d = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                if (!frame_busy) begin
                    pop        = 1'b1;
                    cfg_byte_d = head;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        stall_d    = frame_busy || (state_d == ST_WAIT_FRAME);
        overflow_d = overflow_q || (rx_valid && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cfg_byte_q <= CFG_IDLE_BYTE;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_byte_q <= cfg_byte_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    assign cfg_byte          = cfg_byte_q;
    assign stall_mode_change = stall_q;
    assign overflow          = overflow_q;

endmodule
